mem_rr_arbiter: RTL and testbench
=================================

// Module: mem_rr_arbiter
// PURPOSE
//  Shares one single-port 16-bit memory between N_CORES core load/store units.
//  Uses round-robin arbitration and a per-core req/ack handshake.
//  Each core holds its request stable until its one-cycle ack.
//  Sits between the core array and the shared data memory.
//  Serialises exactly one memory access at a time.
// PARAMETERS
//  N_CORES     4   number of requesting cores (>=2)
//  IDX_W       2   $clog2(N_CORES), width of grant index
//  AW          16  address width
//  DW          16  data width
//  RD_LAT      1   memory read latency in cycles (>=1): mem_rdata valid RD_LAT cycles after mem_addr issued
// PORTS
//  clk        in   1           clock, rising edge
//  reset      in   1           asynchronous, active-high reset
//  req        in   N_CORES     per-core access request, level, held until ack
//  we         in   N_CORES     per-core write enable (1=write, 0=read), valid with req
//  addr       in   N_CORES*AW  per-core address, core i at [i*AW +: AW]
//  wdata      in   N_CORES*DW  per-core write data, core i at [i*DW +: DW]
//  ack        out  N_CORES     one-hot one-cycle completion pulse to granted core
//  rdata      out  DW          read data, valid only in the cycle ack[i]=1 for a read
//  busy       out  1           1 whenever state != IDLE
//  mem_addr   out  AW          address to memory
//  mem_wdata  out  DW          write data to memory
//  mem_wren   out  1           memory write strobe
//  mem_rdata  in   DW          read data from memory
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE.
//    ack, rdata, mem_addr, mem_wdata, mem_wren, busy all 0.
//    last_grant=N_CORES-1, so core 0 has first priority.
//  - Reset mid-transaction aborts the access. No ack is issued.
//  - All outputs are registered.
//  - FSM states: IDLE, ISSUE, WAIT, ACK.
//  - IDLE: if |req, pick first i with req[i]=1, searching last_grant+1 .. last_grant+N_CORES mod N_CORES.
//    Latch g=i, we[g], addr[g], wdata[g]. Set last_grant=g. Go to ISSUE.
//    If no req, stay in IDLE.
//  - ISSUE (1 cycle): mem_addr=latched addr, mem_wdata=latched wdata, mem_wren=latched we.
//    Next state: ACK if write; WAIT if read.
//  - WAIT (RD_LAT cycles, down-counter): mem_wren=0, mem_addr held.
//    Capture mem_rdata into rdata on the last WAIT cycle. Go to ACK.
//  - ACK (1 cycle): ack[g]=1, all other ack bits 0. Go to IDLE.
//    rdata holds the captured read value; it is don't-care for writes.
//  - Latency, req seen at edge T in IDLE:
//    - Write: mem_wren high in cycle T+1; ack high in cycle T+2.
//    - Read: ack high in cycle T+2+RD_LAT.
//    - Minimum spacing between consecutive grants: 3 cycles (write) or 3+RD_LAT (read).
//  - Handshake:
//    - The core drops req in the cycle after ack.
//    - A req still high in the IDLE cycle after ack is a new request.
//    - Round-robin still applies to it, so the same core cannot win again if another core is requesting.
//  - Changes to req/we/addr/wdata after grant are ignored; operands are latched.
//    Dropping req mid-transaction does not cancel it; ack is still pulsed.
//  - Simultaneous requests: exactly one grant per arbitration. No starvation.
//    Every requesting core is served within N_CORES transactions.
//  - mem_wren is never high outside ISSUE. ack is never multi-hot.
// TESTING
//  - Reset, then core2 read addr=0x0010, mem returns 0xBEEF (RD_LAT=1):
//    mem_addr=0x0010 at T+1, ack=4'b0100 and rdata=0xBEEF at T+3.
//  - Core1 write addr=0x0020 wdata=0x1234:
//    mem_wren=1 with mem_addr=0x0020, mem_wdata=0x1234 for exactly 1 cycle at T+1.
//    ack=4'b0010 at T+2.
//  - All 4 cores request reads from reset, each dropping req after its ack:
//    ack order core0,1,2,3, each rdata matches its own address contents.
//  - Fairness: core0 and core3 hold req continuously, re-asserting after each ack:
//    grants alternate 0,3,0,3; neither is served twice in a row.
//  - Assert reset during WAIT of a read:
//    all outputs 0 immediately, no ack; next req from core1 is granted normally.
//  - Core0 changes addr and wdata after grant:
//    memory sees the original latched values; ack is still issued.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory between N_CORES
// load/store units. Exactly one access is in flight at a time. Each core
// gets a one-cycle ack when its access completes, and rdata is valid with
// that ack for reads. All outputs are registered.
//
//  state | meaning
//  ------+----------------------------------------------------------------
//  IDLE  | nothing in flight; arbitrate among pending requests
//  ISSUE | latched address / write data / write strobe presented to memory
//  WAIT  | read in flight; down-counter spans the memory read latency
//  ACK   | one-cycle ack to the granted core, rdata valid for a read
module mem_rr_arbiter #(
    parameter int N_CORES = 4,
    parameter int IDX_W   = 2,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int RD_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CORES-1:0]    req,
    input  logic [N_CORES-1:0]    we,
    input  logic [N_CORES*AW-1:0] addr,
    input  logic [N_CORES*DW-1:0] wdata,
    output logic [N_CORES-1:0]    ack,
    output logic [DW-1:0]         rdata,
    output logic                  busy,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic                  mem_wren,
    input  logic [DW-1:0]         mem_rdata
);
    localparam int               CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_CORES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     g_q, g_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_CORES-1:0]   ack_q, ack_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic [AW-1:0]        mem_addr_q, mem_addr_d;
    logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
    logic                 mem_wren_q, mem_wren_d;
    logic                 busy_q, busy_d;

    logic [AW-1:0]        addr_arr  [N_CORES];
    logic [DW-1:0]        wdata_arr [N_CORES];
    logic                 found;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     g_sel;

    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                  input int offset);
        return IDX_W'((int'(base) + offset) % N_CORES);
    endfunction

    // Unpack the flat per-core operand buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < N_CORES; i++) begin
            addr_arr[i]  = addr[i*AW +: AW];
            wdata_arr[i] = wdata[i*DW +: DW];
        end
    end

    // Rotating-priority search starting at the core after the last winner.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        g_sel = last_grant_q;
        for (int k = 1; k <= N_CORES; k++) begin
            cand = rr_index(last_grant_q, k);
            if (!found && req[cand]) begin
                found = 1'b1;
                g_sel = cand;
            end
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle
    // ahead so every port comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        ack_d        = '0;
        rdata_d      = rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wren_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    g_d          = g_sel;
                    last_grant_d = g_sel;
                    mem_addr_d   = addr_arr[g_sel];
                    mem_wdata_d  = wdata_arr[g_sel];
                    mem_wren_d   = we[g_sel];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // mem_wren_q holds the latched write enable of the winner.
                if (mem_wren_q) begin
                    ack_d[g_q] = 1'b1;
                    state_d    = ACK;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d    = mem_rdata;
                    ack_d[g_q] = 1'b1;
                    state_d    = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            g_q          <= '0;
            last_grant_q <= LAST_RST;
            cnt_q        <= '0;
            ack_q        <= '0;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wren_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wren_q   <= mem_wren_d;
            busy_q       <= busy_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a
// transaction-level model (grant edge + fixed latency per access).
module tb_mem_rr_arbiter;
    localparam int N      = 4;
    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int RD_LAT = 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_wren;
    logic [DW-1:0]   mem_rdata;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mem_rr_arbiter #(
        .N_CORES(N), .IDX_W(2), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .busy(busy), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
    );

    // Memory with RD_LAT-cycle registered read.
    logic [DW-1:0] mem    [0:65535];
    logic [DW-1:0] shadow [0:65535];
    logic [DW-1:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        rd_pipe[0] <= mem[mem_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (mem_wren) mem[mem_addr] = mem_wdata;
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction-level reference model.
    int            n_cyc = 0;
    bit            m_active = 1'b0;
    int            m_core = 0;
    int            m_last = N - 1;
    bit            m_write = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    int            m_g = 0;
    int            m_a = 0;
    logic [N-1:0]  e_ack;
    bit            m_found;
    int            cidx;

    // Compare outputs after each rising edge, then decide the next edge's grant.
    always @(negedge clk) begin
        n_cyc++;
        if (reset) begin
            check("rst_ack", ack, 0);
            check("rst_rdata", rdata, 0);
            check("rst_busy", busy, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_mem_wren", mem_wren, 0);
            m_active = 1'b0;
            m_last   = N - 1;
        end else begin
            e_ack = '0;
            if (m_active && n_cyc == m_a) e_ack[m_core] = 1'b1;
            check("ack", ack, e_ack);
            check("busy", busy, m_active && n_cyc >= m_g && n_cyc <= m_a);
            check("mem_wren", mem_wren, m_active && m_write && n_cyc == m_g);
            if (m_active && n_cyc >= m_g && n_cyc < m_a) check("mem_addr", mem_addr, m_addr);
            if (m_active && n_cyc == m_g) check("mem_wdata", mem_wdata, m_wdata);
            if (m_active && n_cyc == m_a && !m_write) check("rdata", rdata, shadow[m_addr]);

            if (m_active && n_cyc == m_a) begin
                if (m_write) shadow[m_addr] = m_wdata;
                m_active = 1'b0;
            end else if (!m_active && req != '0) begin
                m_found = 1'b0;
                for (int j = 1; j <= N; j++) begin
                    cidx = (m_last + j) % N;
                    if (!m_found && req[cidx]) begin
                        m_found = 1'b1;
                        m_core  = cidx;
                    end
                end
                m_last   = m_core;
                m_write  = we[m_core];
                m_addr   = addr[m_core*AW +: AW];
                m_wdata  = wdata[m_core*DW +: DW];
                m_g      = n_cyc + 1;
                m_a      = m_g + (m_write ? 1 : 1 + RD_LAT);
                m_active = 1'b1;
            end
        end
    end

    task automatic set_core(input int c, input bit r, input bit w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[c] = r;
        we[c]  = w;
        addr[c*AW +: AW]  = a;
        wdata[c*DW +: DW] = d;
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    // Wait (bounded) for an ack; returns the acked core and rdata, -1 on timeout.
    task automatic wait_ack(output int core, output logic [DW-1:0] rd);
        core = -1;
        rd   = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ack != '0) begin
                for (int j = 0; j < N; j++) if (ack[j]) core = j;
                rd = rdata;
                return;
            end
        end
        checks++;
        $display("FAIL ack_timeout: no ack within 40 cycles, one required");
    endtask

    int            c;
    logic [DW-1:0] d;
    int            exp_order [4] = '{0, 3, 0, 3};

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a]    = 16'(a) ^ 16'h5A5A;
            shadow[a] = 16'(a) ^ 16'h5A5A;
        end
        mem[16'h0010]    = 16'hBEEF;
        shadow[16'h0010] = 16'hBEEF;
        for (int i = 0; i < N; i++) begin
            mem[16'h0100 + i]    = 16'hA000 + 16'(i);
            shadow[16'h0100 + i] = 16'hA000 + 16'(i);
        end

        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Core2 read of 0x0010 returning 0xBEEF.
        @(posedge clk); #1 set_core(2, 1, 0, 16'h0010, 16'h0000);
        @(posedge clk); #1;
        check("t1_mem_addr", mem_addr, 16'h0010);
        check("t1_busy", busy, 1);
        @(posedge clk); #1 check("t1_ack_wait", ack, 0);
        @(posedge clk); #1;
        check("t1_ack", ack, 4'b0100);
        check("t1_rdata", rdata, 16'hBEEF);
        set_core(2, 0, 0, 0, 0);

        // Core1 write 0x1234 to 0x0020.
        repeat (2) @(posedge clk);
        #1 set_core(1, 1, 1, 16'h0020, 16'h1234);
        @(posedge clk); #1;
        check("t2_mem_wren", mem_wren, 1);
        check("t2_mem_addr", mem_addr, 16'h0020);
        check("t2_mem_wdata", mem_wdata, 16'h1234);
        @(posedge clk); #1;
        check("t2_wren_once", mem_wren, 0);
        check("t2_ack", ack, 4'b0010);
        set_core(1, 0, 0, 0, 0);

        // All four cores read from reset; served in order 0..3.
        do_reset();
        for (int i = 0; i < N; i++) set_core(i, 1, 0, 16'h0100 + 16'(i), 16'h0000);
        for (int i = 0; i < N; i++) begin
            wait_ack(c, d);
            check("t3_order", c, i);
            check("t3_rdata", d, 16'hA000 + 16'(i));
            if (c >= 0) set_core(c, 0, 0, 0, 0);
        end

        // Fairness: cores 0 and 3 hold req continuously.
        do_reset();
        set_core(0, 1, 0, 16'h0040, 16'h0000);
        set_core(3, 1, 0, 16'h0043, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            wait_ack(c, d);
            check("t4_fair_order", c, exp_order[i]);
        end
        set_core(0, 0, 0, 0, 0);
        set_core(3, 0, 0, 0, 0);

        // Reset in the WAIT cycle of a read aborts it without an ack.
        repeat (3) @(posedge clk);
        #1 set_core(2, 1, 0, 16'h0010, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5_ack", ack, 0);
        check("t5_rdata", rdata, 0);
        check("t5_mem_addr", mem_addr, 0);
        check("t5_mem_wdata", mem_wdata, 0);
        check("t5_mem_wren", mem_wren, 0);
        check("t5_busy", busy, 0);
        set_core(2, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("t5_no_ack", ack, 0);
        set_core(1, 1, 0, 16'h0101, 16'h0000);
        wait_ack(c, d);
        check("t5_core1", c, 1);
        check("t5_core1_rdata", d, 16'hA001);
        set_core(1, 0, 0, 0, 0);

        // Core0 changes operands and drops req right after grant.
        repeat (2) @(posedge clk);
        #1 set_core(0, 1, 1, 16'h0030, 16'h5555);
        @(posedge clk); #1;
        set_core(0, 0, 0, 16'h0031, 16'hAAAA);
        check("t6_mem_wren", mem_wren, 1);
        check("t6_mem_addr", mem_addr, 16'h0030);
        check("t6_mem_wdata", mem_wdata, 16'h5555);
        wait_ack(c, d);
        check("t6_ack_core", c, 0);
        repeat (2) @(posedge clk);
        #1 set_core(3, 1, 0, 16'h0030, 16'h0000);
        wait_ack(c, d);
        check("t6_readback_core", c, 3);
        check("t6_readback", d, 16'h5555);
        set_core(3, 0, 0, 0, 0);

        // Randomized traffic, checked by the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (req[i] && ack[i]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_core(i, 1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
                    else
                        set_core(i, 0, 0, 0, 0);
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    set_core(i, 1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
                end
            end
        end

        // Drain outstanding requests.
        for (int cyc = 0; cyc < 200 && req != '0; cyc++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) if (req[i] && ack[i]) set_core(i, 0, 0, 0, 0);
        end
        if (req != '0) begin
            checks++;
            $display("FAIL drain: req=0x%0h still pending, 0 required", req);
        end
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
